// File: rtl/level_pulse_array_if.sv
`default_nettype none
// ============================================================================
// Module   : level_pulse_array_if
// Brief    : Raw-input / debounced-output bundle for level_pulse_array.
// Revision : 1.0 - initial release
// ============================================================================
interface level_pulse_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   in;
  logic [2*CHANNELS-1:0] edge_mode;
  logic [CHANNELS-1:0]   repeat_en;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   pulse;

  modport master (output in, edge_mode, repeat_en, input level, pulse);
  modport slave  (input in, edge_mode, repeat_en, output level, pulse);
endinterface
`default_nettype wire

// File: rtl/level_pulse_array.sv
`default_nettype none
// ============================================================================
// Module   : level_pulse_array
// Brief    : Per-channel synchronise, debounce, edge pulse and auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module level_pulse_array #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  level_pulse_array_if.slave bus
);

  localparam int C_DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int C_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_RW   = $clog2(C_RMAX) + 1;

  localparam logic [C_DW-1:0] C_DEB_LAST    = C_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_RW-1:0] C_DELAY_LAST  = C_RW'(REPEAT_DELAY - 1);
  localparam logic [C_RW-1:0] C_PERIOD_LAST = C_RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    DELAY = 2'd2,
    RPT   = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [C_DW-1:0]        r_dcnt;
      logic [C_RW-1:0]        r_rcnt;
      logic                   r_level;
      logic                   r_pulse;
      state_t                 r_state;

      logic w_s;
      logic w_accept;
      logic w_rise;
      logic w_fall;
      logic w_mode_rise;
      logic w_mode_fall;
      logic w_rpt_ok;
      logic w_rpt_due;

      assign w_s         = r_sync[SYNC_STAGES-1];
      assign w_accept    = (w_s != r_level) && (r_dcnt == C_DEB_LAST);
      assign w_rise      = w_accept && w_s;
      assign w_fall      = w_accept && !w_s;
      assign w_mode_rise = bus.edge_mode[2*gi];
      assign w_mode_fall = bus.edge_mode[2*gi+1];
      assign w_rpt_ok    = bus.repeat_en[gi] && w_mode_rise;
      assign w_rpt_due   = (r_state == DELAY) ? (r_rcnt == C_DELAY_LAST)
                                              : (r_rcnt == C_PERIOD_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync  <= '0;
          r_dcnt  <= '0;
          r_rcnt  <= '0;
          r_level <= 1'b0;
          r_pulse <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.in[gi]};
          r_pulse <= 1'b0;

          if (w_s == r_level) begin
            r_dcnt <= '0;
          end else if (w_accept) begin
            r_level <= w_s;
            r_dcnt  <= '0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end

          // A fall always wins: any repeat due this cycle is dropped.
          if (w_fall) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_pulse <= w_mode_fall;
          end else if (w_rise) begin
            r_pulse <= w_mode_rise;
            r_rcnt  <= '0;
            r_state <= w_rpt_ok ? DELAY : HELD;
          end else begin
            case (r_state)
              DELAY, RPT: begin
                if (!w_rpt_ok) begin
                  r_state <= HELD;
                end else if (w_rpt_due) begin
                  r_pulse <= 1'b1;
                  r_state <= RPT;
                  r_rcnt  <= '0;
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      assign bus.level[gi] = r_level;
      assign bus.pulse[gi] = r_pulse;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_level_pulse_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_pulse_array
// Brief    : Scenario tasks plus random traffic against a timing-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_level_pulse_array;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam int LAT = SS + DC - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  level_pulse_array_if #(.CHANNELS(CH)) bus ();

  level_pulse_array #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: input delay line, mismatch run length, and time since rise.
  logic [SS-1:0] m_hist [CH];
  logic [CH-1:0] m_lvl, m_pls;
  int            m_run [CH];
  int            m_age [CH];
  bit            m_act [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_hist[c] = '0; m_run[c] = 0; m_age[c] = 0; m_act[c] = 0;
    end
    m_lvl = '0; m_pls = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      logic s, mr, mf, rise, fall, np;
      s = m_hist[c][SS-1];
      mr = bus.edge_mode[2*c];
      mf = bus.edge_mode[2*c+1];
      rise = 0; fall = 0; np = 0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == DC) begin
          m_run[c] = 0; m_lvl[c] = s; rise = s; fall = !s;
        end
      end else m_run[c] = 0;
      if (fall) begin
        np = mf; m_act[c] = 0;
      end else if (rise) begin
        np = mr; m_act[c] = bus.repeat_en[c] && mr; m_age[c] = 0;
      end else if (m_act[c]) begin
        if (!bus.repeat_en[c] || !mr) m_act[c] = 0;
        else begin
          m_age[c]++;
          if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0)) np = 1;
        end
      end
      m_pls[c] = np;
      m_hist[c] = {m_hist[c][SS-2:0], bus.in[c]};
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    bus.in = '0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    bus.in = '0; bus.edge_mode = '0; bus.repeat_en = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.level !== '0 || bus.pulse !== '0) begin
      errors++;
      $display("FAIL reset level=%b pulse=%b want 0/0", bus.level, bus.pulse);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_rise();
    int first, cnt;
    first = -1; cnt = 0;
    settle();
    bus.edge_mode = {6'($urandom), 2'b01};
    bus.repeat_en = '0;
    bus.in[0] = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      checks++;
      if (bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL rise e=%0d level=%b/%b pulse=%b/%b", e, bus.level, m_lvl, bus.pulse, m_pls);
      end
      if (bus.pulse[0]) begin cnt++; if (first < 0) first = e; end
    end
    checks++;
    if (first != LAT || cnt != 1) begin
      errors++;
      $display("FAIL rise_timing first=%0d count=%0d want %0d/1", first, cnt, LAT);
    end
  endtask

  task automatic test_glitch();
    int glen;
    bit seen;
    seen = 0;
    glen = $urandom_range(1, DC - 1);
    settle();
    bus.edge_mode[3:2] = 2'b11;
    bus.in[1] = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e == glen) bus.in[1] = 1'b0;
      tick();
      checks++;
      if (bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL glitch e=%0d level=%b/%b pulse=%b/%b", e, bus.level, m_lvl, bus.pulse, m_pls);
      end
      if (bus.level[1] || bus.pulse[1]) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL glitch_len%0d level/pulse on ch1 rose, want none", glen);
    end
  endtask

  task automatic test_both_edges();
    int p [$];
    settle();
    bus.edge_mode[5:4] = 2'b11;
    bus.repeat_en[2] = 1'b0;
    bus.in[2] = 1'b1;
    for (int e = 0; e < 40; e++) begin
      if (e == 20) bus.in[2] = 1'b0;
      tick();
      checks++;
      if (bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL both e=%0d level=%b/%b pulse=%b/%b", e, bus.level, m_lvl, bus.pulse, m_pls);
      end
      if (bus.pulse[2]) p.push_back(e);
    end
    checks++;
    if (p.size() != 2 || p[0] != LAT || p[1] != 20 + LAT) begin
      errors++;
      $display("FAIL both_edges count=%0d want 2 at %0d,%0d", p.size(), LAT, 20 + LAT);
    end
  endtask

  task automatic test_repeat();
    bit exp;
    settle();
    bus.edge_mode[7:6] = 2'b01;
    bus.repeat_en[3] = 1'b1;
    bus.in[3] = 1'b1;
    for (int e = 0; e < 50; e++) begin
      if (e == 30) bus.in[3] = 1'b0;
      tick();
      exp = (e == LAT) ||
            (e >= LAT + RD && e < 30 + LAT && (e - LAT - RD) % RP == 0);
      checks++;
      if (bus.pulse[3] !== exp || bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL repeat e=%0d pulse3=%b want %b level=%b/%b", e, bus.pulse[3], exp, bus.level, m_lvl);
      end
    end
  endtask

  task automatic test_drop_repeat();
    int late;
    late = 0;
    settle();
    bus.edge_mode[7:6] = 2'b01;
    bus.repeat_en[3] = 1'b1;
    bus.in[3] = 1'b1;
    for (int e = 0; e < 50; e++) begin
      if (e == 20) bus.repeat_en[3] = 1'b0;
      if (e == 30) bus.in[3] = 1'b0;
      tick();
      checks++;
      if (bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL drop e=%0d level=%b/%b pulse=%b/%b", e, bus.level, m_lvl, bus.pulse, m_pls);
      end
      if (e >= 20 && bus.pulse[3]) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL drop_repeat pulses_after_drop=%0d want 0", late);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    settle();
    bus.edge_mode[1:0] = 2'b01;
    bus.repeat_en[0] = 1'b1;
    bus.in[0] = 1'b1;
    for (int e = 0; e <= LAT; e++) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.level !== '0 || bus.pulse !== '0) begin
      errors++;
      $display("FAIL async_reset level=%b pulse=%b want 0/0", bus.level, bus.pulse);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL post_reset e=%0d level=%b/%b pulse=%b/%b", e, bus.level, m_lvl, bus.pulse, m_pls);
      end
      if (bus.pulse[0] && first < 0) first = e;
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL reset_rearm first_pulse=%0d want %0d", first, LAT);
    end
  endtask

  task automatic test_random();
    settle();
    for (int e = 0; e < 800; e++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) bus.in[c] = ~bus.in[c];
      if ($urandom_range(0, 39) == 0) bus.edge_mode = 8'($urandom);
      if ($urandom_range(0, 59) == 0) bus.repeat_en = 4'($urandom);
      tick();
      checks++;
      if (bus.level !== m_lvl || bus.pulse !== m_pls) begin
        errors++;
        $display("FAIL random e=%0d level=%b/%b pulse=%b/%b", e, bus.level, m_lvl, bus.pulse, m_pls);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise();
    test_glitch();
    test_both_edges();
    test_repeat();
    test_drop_repeat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/level_pulse_array.md
Name: level_pulse_array

Overview:
- Parametrised multi-channel level-to-pulse converter for raw switch and button inputs.
- Per channel:
  - synchronise the asynchronous level
  - debounce it
  - emit single-cycle pulses on selected edges
  - optionally auto-repeat while the input is held
- Sits between board inputs and control FSMs. Replaces single-channel, undebounced, rise-only pulse generation.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flop depth (>=2).
- DEBOUNCE_CYCLES, 4: consecutive cycles a new synchronised level must hold before acceptance (>=1).
- REPEAT_DELAY, 8: cycles from the rising pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 3: cycles between subsequent repeat pulses (>=1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  CHANNELS  raw asynchronous levels, one bit per channel.
- edge_mode  input  2*CHANNELS  per channel, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both. Sampled every cycle.
- repeat_en  input  CHANNELS  per-channel auto-repeat enable.
- level  output  CHANNELS  debounced level.
- pulse  output  CHANNELS  single-cycle event pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - synchroniser flops, level, pulse, counters all 0
  - every channel FSM to IDLE
  - release is taken on the next posedge; outputs stay 0 until real events.
- Channels are fully independent and share only clk/rst_n.
- Synchroniser: SYNC_STAGES-flop chain per channel; s = last stage.
- Debounce, per channel, with counter dcnt of width $clog2(DEBOUNCE_CYCLES)+1:
  - s == level: dcnt <= 0.
  - s != level and dcnt == DEBOUNCE_CYCLES-1: level <= s, dcnt <= 0. This is the accept event.
  - otherwise: dcnt++.
  - A glitch shorter than DEBOUNCE_CYCLES at s never changes level.
- Latency: take the first posedge sampling a new stable input as edge 0. Level updates at edge SYNC_STAGES+DEBOUNCE_CYCLES-1 (edge 5 at defaults).
- pulse is registered and is high for exactly one cycle after the edge where:
  - a rise is accepted and edge_mode[2i] = 1, or
  - a fall is accepted and edge_mode[2i+1] = 1, or
  - a repeat fires.
- Edge pulse and level update on the same edge; pulse is never combinational from in.
- FSM per channel: IDLE, HELD, DELAY, RPT. Repeat counter rcnt is wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE (level 0), on accepted rise:
    - to DELAY with rcnt <= 0 if repeat_en = 1 and edge_mode[2i] = 1
    - else to HELD.
  - HELD (level 1, no repeats): accepted fall -> IDLE. Enabling repeat_en while in HELD has no effect until the next rise.
  - DELAY: rcnt++ each cycle. When rcnt == REPEAT_DELAY-1: fire repeat pulse, go to RPT, rcnt <= 0.
  - RPT: rcnt++. When rcnt == REPEAT_PERIOD-1: fire repeat pulse, rcnt <= 0. Continues indefinitely while held.
  - DELAY or RPT with repeat_en = 0 or edge_mode[2i] = 0: to HELD, no pulse that cycle.
  - Any state with accepted fall: to IDLE immediately. A pending repeat in the same cycle is cancelled; only the fall pulse (if enabled) fires.
- Repeat timing: rise pulse registered at edge E gives repeats at edges E+REPEAT_DELAY, then +REPEAT_PERIOD each.
- Simultaneous events: at most one pulse per channel per cycle. Pulses are not counted or queued.
- edge_mode changes mid-hold: affect only events accepted after the change.
- Mid-operation reset: all pulses drop immediately. A level held high through reset is re-accepted as a fresh rise after release plus full latency.

Test Plan:
- Reset, then raise in[0] and hold, mode 01, repeat_en 0 -> level[0] and pulse[0] rise at edge 5; pulse high exactly 1 cycle; no further pulses.
- 3-cycle glitch high on in[1], DEBOUNCE_CYCLES 4 -> level[1] and pulse[1] stay 0 throughout.
- Mode 11 on ch2, in high for 20 cycles then low -> exactly two pulses: edge 5 after the rise, and edge 5 after the fall.
- ch3 repeat_en 1, REPEAT_DELAY 8, REPEAT_PERIOD 3, held 30 cycles -> pulses at E, E+8, E+11, E+14, ... until the fall is accepted, then none.
- Drop repeat_en during RPT, then release in -> repeats stop next cycle; fall gives no pulse in mode 01.
- Assert rst_n low mid-DELAY with in held high -> pulse/level go 0 asynchronously; after release a rise pulse appears at edge 5.
